// File: rtl/fpu_pkg.sv
// Shared types and constants for the FPU request front-end.
package fpu_pkg;

    localparam logic        OP_ADD  = 1'b0;
    localparam logic        OP_MUL  = 1'b1;
    localparam logic [31:0] FPU_NAN = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;

    typedef struct packed {
        logic        op;
        logic [31:0] data1;
        logic [31:0] data2;
    } fpu_req_t;

endpackage

// File: rtl/fpu_issue_queue_if.sv
// Request, FPU-side and response signals of the issue queue.
interface fpu_issue_queue_if;

    logic        Req_Valid;
    logic        Req_Ready;
    logic        Req_Op;
    logic [31:0] Req_Data1;
    logic [31:0] Req_Data2;
    logic [31:0] Data1;
    logic [31:0] Data2;
    logic        Op;
    logic        In_Data_Valid;
    logic [31:0] Data_Out;
    logic        Out_Data_Valid;
    logic        Rsp_Valid;
    logic        Rsp_Ready;
    logic [31:0] Rsp_Data;
    logic        Rsp_Timeout;
    logic        Busy;

    modport slave (
        input  Req_Valid, Req_Op, Req_Data1, Req_Data2, Data_Out, Out_Data_Valid, Rsp_Ready,
        output Req_Ready, Data1, Data2, Op, In_Data_Valid, Rsp_Valid, Rsp_Data, Rsp_Timeout, Busy
    );

    modport master (
        output Req_Valid, Req_Op, Req_Data1, Req_Data2, Data_Out, Out_Data_Valid, Rsp_Ready,
        input  Req_Ready, Data1, Data2, Op, In_Data_Valid, Rsp_Valid, Rsp_Data, Rsp_Timeout, Busy
    );

endinterface

// File: rtl/fpu_req_fifo.sv
// DEPTH-entry request FIFO; pointers carry an extra wrap bit to tell full from empty.
module fpu_req_fifo
    import fpu_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic     Clock,
    input  logic     Reset,
    input  logic     push,
    input  fpu_req_t push_data,
    input  logic     pop,
    output fpu_req_t pop_data,
    output logic     full,
    output logic     empty
);

    localparam int unsigned AW      = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    fpu_req_t    mem [DEPTH];

    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty    = (wr_ptr == rd_ptr);
    assign pop_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full)
                wr_ptr <= wr_ptr + PTR_ONE;
            if (pop && !empty)
                rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge Clock) begin
        if (push && !full)
            mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/fpu_issue_queue.sv
// FPU front-end: buffers requests, keeps one operation in flight, returns result or timeout.
module fpu_issue_queue
    import fpu_pkg::*;
#(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic               Clock,
    input  logic               Reset,
    fpu_issue_queue_if.slave   bus
);

    localparam int unsigned     CW       = $clog2(TIMEOUT);
    localparam logic [CW-1:0]   CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0]   CNT_ONE  = CW'(1);

    state_t        state;
    state_t        next_state;
    fpu_req_t      req_in;
    fpu_req_t      head;
    logic          fifo_full;
    logic          fifo_empty;
    logic          pop;
    logic          issue;
    logic          cap_data;
    logic          cap_timeout;
    logic          rsp_valid;
    logic [CW-1:0] wait_cnt;
    logic [31:0]   data1_q;
    logic [31:0]   data2_q;
    logic          op_q;
    logic [31:0]   rsp_data_q;
    logic          rsp_timeout_q;

    assign req_in = '{op: bus.Req_Op, data1: bus.Req_Data1, data2: bus.Req_Data2};

    fpu_req_fifo #(.DEPTH(DEPTH)) u_fifo (
        .Clock     (Clock),
        .Reset     (Reset),
        .push      (bus.Req_Valid),
        .push_data (req_in),
        .pop       (pop),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset)
            state <= IDLE;
        else
            state <= next_state;
    end

    // Out_Data_Valid is only looked at in WAIT, and there it beats the timeout.
    always_comb begin
        next_state  = state;
        pop         = 1'b0;
        issue       = 1'b0;
        cap_data    = 1'b0;
        cap_timeout = 1'b0;
        rsp_valid   = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    next_state = ISSUE;
                end
            end
            ISSUE: begin
                issue      = 1'b1;
                next_state = WAIT;
            end
            WAIT: begin
                if (bus.Out_Data_Valid) begin
                    cap_data   = 1'b1;
                    next_state = HOLD;
                end else if (wait_cnt == CNT_LAST) begin
                    cap_timeout = 1'b1;
                    next_state  = HOLD;
                end
            end
            HOLD: begin
                rsp_valid = 1'b1;
                if (bus.Rsp_Ready)
                    next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            data1_q       <= '0;
            data2_q       <= '0;
            op_q          <= 1'b0;
            wait_cnt      <= '0;
            rsp_data_q    <= '0;
            rsp_timeout_q <= 1'b0;
        end else begin
            if (pop) begin
                data1_q <= head.data1;
                data2_q <= head.data2;
                op_q    <= head.op;
            end
            if (issue)
                wait_cnt <= '0;
            else if (state == WAIT && wait_cnt != '1)
                wait_cnt <= wait_cnt + CNT_ONE;
            if (cap_data) begin
                rsp_data_q    <= bus.Data_Out;
                rsp_timeout_q <= 1'b0;
            end else if (cap_timeout) begin
                rsp_data_q    <= FPU_NAN;
                rsp_timeout_q <= 1'b1;
            end
        end
    end

    assign bus.Req_Ready     = !fifo_full;
    assign bus.Data1         = data1_q;
    assign bus.Data2         = data2_q;
    assign bus.Op            = op_q;
    assign bus.In_Data_Valid = issue;
    assign bus.Rsp_Valid     = rsp_valid;
    assign bus.Rsp_Data      = rsp_data_q;
    assign bus.Rsp_Timeout   = rsp_timeout_q;
    assign bus.Busy          = (state != IDLE) || !fifo_empty;

endmodule

// File: doc/fpu_issue_queue.md
# fpu_issue_queue

Request front-end placed directly upstream of the FPU. Accepts add/multiply requests over a valid/ready interface and buffers them in a small FIFO. Issues them to the FPU one at a time with a single-cycle In_Data_Valid pulse, waits for Out_Data_Valid (bounded by a timeout), then returns the result over a valid/ready response interface. Only one operation is ever outstanding in the FPU.

## Interface
- DEPTH, 4, request FIFO entries; power of two, ≥2
- TIMEOUT, 64, WAIT cycles allowed before a result is declared lost; ≥2
- Clock  in  1  single clock; all state updates on rising edge
- Reset  in  1  asynchronous, active-high
- Req_Valid  in  1  request present
- Req_Ready  out  1  request accepted when Req_Valid && Req_Ready at an edge
- Req_Op  in  1  0 = add, 1 = multiply
- Req_Data1  in  32  IEEE-754 single operand A
- Req_Data2  in  32  IEEE-754 single operand B
- Data1  out  32  operand A to FPU
- Data2  out  32  operand B to FPU
- Op  out  1  opcode to FPU
- In_Data_Valid  out  1  one-cycle issue pulse to FPU
- Data_Out  in  32  FPU result
- Out_Data_Valid  in  1  FPU result strobe
- Rsp_Valid  out  1  response present
- Rsp_Ready  in  1  response consumed when Rsp_Valid && Rsp_Ready at an edge
- Rsp_Data  out  32  result, or 32'hFFFFFFFF on timeout
- Rsp_Timeout  out  1  response produced by timeout
- Busy  out  1  FSM not in IDLE or FIFO non-empty

## Operation
- FIFO uses read/write pointers with one extra wrap bit; full = MSBs differ and indices equal; empty = pointers equal.
- Req_Ready = !full, from registered pointers only. A push when full is never accepted, even if a pop happens in the same cycle.
- FSM states:
  - IDLE: if FIFO non-empty, pop the head into Data1/Data2/Op registers → ISSUE.
  - ISSUE: In_Data_Valid = 1 for exactly this cycle; clear timeout counter → WAIT.
  - WAIT: Data1/Data2/Op held stable; counter increments each cycle.
    - Out_Data_Valid sampled high: capture Data_Out into Rsp_Data, Rsp_Timeout = 0 → HOLD.
    - Otherwise, counter reaches TIMEOUT−1: Rsp_Data = 32'hFFFFFFFF, Rsp_Timeout = 1 → HOLD.
    - Out_Data_Valid in the final WAIT cycle wins over timeout.
  - HOLD: Rsp_Valid = 1; Rsp_Data and Rsp_Timeout stable; on Rsp_Ready → IDLE.
- Out_Data_Valid outside WAIT is ignored. This covers a late result after a timeout and a stray strobe.
- Push and pop in the same cycle are both performed (not full, not empty).
- Counter width is $clog2(TIMEOUT); it saturates and never wraps.

## Timing
- Reset values:
  - Req_Ready = 1; Busy = 0.
  - In_Data_Valid, Rsp_Valid, Rsp_Timeout = 0.
  - Data1, Data2, Op, Rsp_Data = 0.
  - FIFO empty; FSM IDLE.
- Reset asserted mid-operation clears everything immediately (asynchronous). Any in-flight FPU result arriving afterwards is ignored.
- Latency, request accepted at edge E0 with an empty queue and IDLE FSM:
  - Pop at E1.
  - In_Data_Valid high in the cycle after E1 (ISSUE).
  - WAIT from the cycle after E2.
- Rsp_Valid rises the cycle after the edge that samples Out_Data_Valid in WAIT.
- Timeout response: Rsp_Valid rises exactly TIMEOUT cycles after WAIT entry.
- Back-to-back throughput: next In_Data_Valid at the earliest 2 cycles after the response handshake edge (HOLD → IDLE → ISSUE).
- Maximum accepted before Req_Ready falls: DEPTH queued + 1 in flight.

## Structure
- Shared package fpu_pkg:
  - OP_ADD = 1'b0, OP_MUL = 1'b1
  - FPU_NAN = 32'hFFFFFFFF
  - state enum {IDLE, ISSUE, WAIT, HOLD}
  - request struct {op, data1, data2} (65 bits)
- Sub-module fpu_req_fifo: parameterised DEPTH × 65-bit synchronous FIFO with push/pop/full/empty and async reset.
- FSM, operand registers and timeout counter live in fpu_issue_queue.

## Test plan
- Single add: Req 0x3F8CCCCD, 0x400CCCCD, Op 0; FPU model strobes 0x40533334 five cycles after In_Data_Valid → In_Data_Valid high for exactly 1 cycle, 2 cycles after acceptance; Rsp_Data 0x40533334, Rsp_Timeout 0.
- Backpressure: FPU model silent until released, 6 requests offered back-to-back, DEPTH 4 → 5 accepted, Req_Ready low on the 6th. After release, responses arrive in request order and never more than one In_Data_Valid per response.
- Timeout: multiply 0x3F8CCCCD × 0xC00CCCCD, FPU never strobes → Rsp_Valid exactly TIMEOUT cycles after WAIT entry, Rsp_Data 0xFFFFFFFF, Rsp_Timeout 1. A later strobe of 0xC01AE148 is ignored.
- Response stall: Rsp_Ready low for 10 cycles with 2 queued → Rsp_Data stable, no In_Data_Valid for the second request until the handshake, then issue 2 cycles later.
- Reset mid-WAIT: assert Reset between edges → all outputs at reset values immediately; a following Out_Data_Valid with 0x40000000 produces no response.
- Boundary: Out_Data_Valid in the last WAIT cycle (cycle TIMEOUT−1) → Rsp_Timeout 0 with FPU data; a stray Out_Data_Valid in IDLE → no response, Busy stays 0.
